// File: rtl/aes_pkg.sv
// Shared AES-128 definitions: FSM states, S-boxes, GF(2^8) helpers, Rcon.
package aes_pkg;

    typedef enum logic [2:0] {
        S_LOAD,
        S_KEYEXP,
        S_INIT,
        S_ROUND,
        S_FINAL,
        S_DONE
    } fsm_state_t;

    localparam int NR = 10;

    // Indexed directly by the 4-bit round counter; unused slots are zero.
    localparam logic [7:0] RCON [0:15] = '{
        8'h00, 8'h01, 8'h02, 8'h04, 8'h08, 8'h10, 8'h20, 8'h40,
        8'h80, 8'h1b, 8'h36, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00
    };

    function automatic logic [7:0] sbox(input logic [7:0] a);
        logic [7:0] r;
        case (a)
            8'h00: r = 8'h63; 8'h01: r = 8'h7c; 8'h02: r = 8'h77; 8'h03: r = 8'h7b; 8'h04: r = 8'hf2; 8'h05: r = 8'h6b; 8'h06: r = 8'h6f; 8'h07: r = 8'hc5; 8'h08: r = 8'h30; 8'h09: r = 8'h01; 8'h0a: r = 8'h67; 8'h0b: r = 8'h2b; 8'h0c: r = 8'hfe; 8'h0d: r = 8'hd7; 8'h0e: r = 8'hab; 8'h0f: r = 8'h76;
            8'h10: r = 8'hca; 8'h11: r = 8'h82; 8'h12: r = 8'hc9; 8'h13: r = 8'h7d; 8'h14: r = 8'hfa; 8'h15: r = 8'h59; 8'h16: r = 8'h47; 8'h17: r = 8'hf0; 8'h18: r = 8'had; 8'h19: r = 8'hd4; 8'h1a: r = 8'ha2; 8'h1b: r = 8'haf; 8'h1c: r = 8'h9c; 8'h1d: r = 8'ha4; 8'h1e: r = 8'h72; 8'h1f: r = 8'hc0;
            8'h20: r = 8'hb7; 8'h21: r = 8'hfd; 8'h22: r = 8'h93; 8'h23: r = 8'h26; 8'h24: r = 8'h36; 8'h25: r = 8'h3f; 8'h26: r = 8'hf7; 8'h27: r = 8'hcc; 8'h28: r = 8'h34; 8'h29: r = 8'ha5; 8'h2a: r = 8'he5; 8'h2b: r = 8'hf1; 8'h2c: r = 8'h71; 8'h2d: r = 8'hd8; 8'h2e: r = 8'h31; 8'h2f: r = 8'h15;
            8'h30: r = 8'h04; 8'h31: r = 8'hc7; 8'h32: r = 8'h23; 8'h33: r = 8'hc3; 8'h34: r = 8'h18; 8'h35: r = 8'h96; 8'h36: r = 8'h05; 8'h37: r = 8'h9a; 8'h38: r = 8'h07; 8'h39: r = 8'h12; 8'h3a: r = 8'h80; 8'h3b: r = 8'he2; 8'h3c: r = 8'heb; 8'h3d: r = 8'h27; 8'h3e: r = 8'hb2; 8'h3f: r = 8'h75;
            8'h40: r = 8'h09; 8'h41: r = 8'h83; 8'h42: r = 8'h2c; 8'h43: r = 8'h1a; 8'h44: r = 8'h1b; 8'h45: r = 8'h6e; 8'h46: r = 8'h5a; 8'h47: r = 8'ha0; 8'h48: r = 8'h52; 8'h49: r = 8'h3b; 8'h4a: r = 8'hd6; 8'h4b: r = 8'hb3; 8'h4c: r = 8'h29; 8'h4d: r = 8'he3; 8'h4e: r = 8'h2f; 8'h4f: r = 8'h84;
            8'h50: r = 8'h53; 8'h51: r = 8'hd1; 8'h52: r = 8'h00; 8'h53: r = 8'hed; 8'h54: r = 8'h20; 8'h55: r = 8'hfc; 8'h56: r = 8'hb1; 8'h57: r = 8'h5b; 8'h58: r = 8'h6a; 8'h59: r = 8'hcb; 8'h5a: r = 8'hbe; 8'h5b: r = 8'h39; 8'h5c: r = 8'h4a; 8'h5d: r = 8'h4c; 8'h5e: r = 8'h58; 8'h5f: r = 8'hcf;
            8'h60: r = 8'hd0; 8'h61: r = 8'hef; 8'h62: r = 8'haa; 8'h63: r = 8'hfb; 8'h64: r = 8'h43; 8'h65: r = 8'h4d; 8'h66: r = 8'h33; 8'h67: r = 8'h85; 8'h68: r = 8'h45; 8'h69: r = 8'hf9; 8'h6a: r = 8'h02; 8'h6b: r = 8'h7f; 8'h6c: r = 8'h50; 8'h6d: r = 8'h3c; 8'h6e: r = 8'h9f; 8'h6f: r = 8'ha8;
            8'h70: r = 8'h51; 8'h71: r = 8'ha3; 8'h72: r = 8'h40; 8'h73: r = 8'h8f; 8'h74: r = 8'h92; 8'h75: r = 8'h9d; 8'h76: r = 8'h38; 8'h77: r = 8'hf5; 8'h78: r = 8'hbc; 8'h79: r = 8'hb6; 8'h7a: r = 8'hda; 8'h7b: r = 8'h21; 8'h7c: r = 8'h10; 8'h7d: r = 8'hff; 8'h7e: r = 8'hf3; 8'h7f: r = 8'hd2;
            8'h80: r = 8'hcd; 8'h81: r = 8'h0c; 8'h82: r = 8'h13; 8'h83: r = 8'hec; 8'h84: r = 8'h5f; 8'h85: r = 8'h97; 8'h86: r = 8'h44; 8'h87: r = 8'h17; 8'h88: r = 8'hc4; 8'h89: r = 8'ha7; 8'h8a: r = 8'h7e; 8'h8b: r = 8'h3d; 8'h8c: r = 8'h64; 8'h8d: r = 8'h5d; 8'h8e: r = 8'h19; 8'h8f: r = 8'h73;
            8'h90: r = 8'h60; 8'h91: r = 8'h81; 8'h92: r = 8'h4f; 8'h93: r = 8'hdc; 8'h94: r = 8'h22; 8'h95: r = 8'h2a; 8'h96: r = 8'h90; 8'h97: r = 8'h88; 8'h98: r = 8'h46; 8'h99: r = 8'hee; 8'h9a: r = 8'hb8; 8'h9b: r = 8'h14; 8'h9c: r = 8'hde; 8'h9d: r = 8'h5e; 8'h9e: r = 8'h0b; 8'h9f: r = 8'hdb;
            8'ha0: r = 8'he0; 8'ha1: r = 8'h32; 8'ha2: r = 8'h3a; 8'ha3: r = 8'h0a; 8'ha4: r = 8'h49; 8'ha5: r = 8'h06; 8'ha6: r = 8'h24; 8'ha7: r = 8'h5c; 8'ha8: r = 8'hc2; 8'ha9: r = 8'hd3; 8'haa: r = 8'hac; 8'hab: r = 8'h62; 8'hac: r = 8'h91; 8'had: r = 8'h95; 8'hae: r = 8'he4; 8'haf: r = 8'h79;
            8'hb0: r = 8'he7; 8'hb1: r = 8'hc8; 8'hb2: r = 8'h37; 8'hb3: r = 8'h6d; 8'hb4: r = 8'h8d; 8'hb5: r = 8'hd5; 8'hb6: r = 8'h4e; 8'hb7: r = 8'ha9; 8'hb8: r = 8'h6c; 8'hb9: r = 8'h56; 8'hba: r = 8'hf4; 8'hbb: r = 8'hea; 8'hbc: r = 8'h65; 8'hbd: r = 8'h7a; 8'hbe: r = 8'hae; 8'hbf: r = 8'h08;
            8'hc0: r = 8'hba; 8'hc1: r = 8'h78; 8'hc2: r = 8'h25; 8'hc3: r = 8'h2e; 8'hc4: r = 8'h1c; 8'hc5: r = 8'ha6; 8'hc6: r = 8'hb4; 8'hc7: r = 8'hc6; 8'hc8: r = 8'he8; 8'hc9: r = 8'hdd; 8'hca: r = 8'h74; 8'hcb: r = 8'h1f; 8'hcc: r = 8'h4b; 8'hcd: r = 8'hbd; 8'hce: r = 8'h8b; 8'hcf: r = 8'h8a;
            8'hd0: r = 8'h70; 8'hd1: r = 8'h3e; 8'hd2: r = 8'hb5; 8'hd3: r = 8'h66; 8'hd4: r = 8'h48; 8'hd5: r = 8'h03; 8'hd6: r = 8'hf6; 8'hd7: r = 8'h0e; 8'hd8: r = 8'h61; 8'hd9: r = 8'h35; 8'hda: r = 8'h57; 8'hdb: r = 8'hb9; 8'hdc: r = 8'h86; 8'hdd: r = 8'hc1; 8'hde: r = 8'h1d; 8'hdf: r = 8'h9e;
            8'he0: r = 8'he1; 8'he1: r = 8'hf8; 8'he2: r = 8'h98; 8'he3: r = 8'h11; 8'he4: r = 8'h69; 8'he5: r = 8'hd9; 8'he6: r = 8'h8e; 8'he7: r = 8'h94; 8'he8: r = 8'h9b; 8'he9: r = 8'h1e; 8'hea: r = 8'h87; 8'heb: r = 8'he9; 8'hec: r = 8'hce; 8'hed: r = 8'h55; 8'hee: r = 8'h28; 8'hef: r = 8'hdf;
            8'hf0: r = 8'h8c; 8'hf1: r = 8'ha1; 8'hf2: r = 8'h89; 8'hf3: r = 8'h0d; 8'hf4: r = 8'hbf; 8'hf5: r = 8'he6; 8'hf6: r = 8'h42; 8'hf7: r = 8'h68; 8'hf8: r = 8'h41; 8'hf9: r = 8'h99; 8'hfa: r = 8'h2d; 8'hfb: r = 8'h0f; 8'hfc: r = 8'hb0; 8'hfd: r = 8'h54; 8'hfe: r = 8'hbb; 8'hff: r = 8'h16;
            default: r = 8'h00;
        endcase
        return r;
    endfunction

    function automatic logic [7:0] inv_sbox(input logic [7:0] a);
        logic [7:0] r;
        case (a)
            8'h00: r = 8'h52; 8'h01: r = 8'h09; 8'h02: r = 8'h6a; 8'h03: r = 8'hd5; 8'h04: r = 8'h30; 8'h05: r = 8'h36; 8'h06: r = 8'ha5; 8'h07: r = 8'h38; 8'h08: r = 8'hbf; 8'h09: r = 8'h40; 8'h0a: r = 8'ha3; 8'h0b: r = 8'h9e; 8'h0c: r = 8'h81; 8'h0d: r = 8'hf3; 8'h0e: r = 8'hd7; 8'h0f: r = 8'hfb;
            8'h10: r = 8'h7c; 8'h11: r = 8'he3; 8'h12: r = 8'h39; 8'h13: r = 8'h82; 8'h14: r = 8'h9b; 8'h15: r = 8'h2f; 8'h16: r = 8'hff; 8'h17: r = 8'h87; 8'h18: r = 8'h34; 8'h19: r = 8'h8e; 8'h1a: r = 8'h43; 8'h1b: r = 8'h44; 8'h1c: r = 8'hc4; 8'h1d: r = 8'hde; 8'h1e: r = 8'he9; 8'h1f: r = 8'hcb;
            8'h20: r = 8'h54; 8'h21: r = 8'h7b; 8'h22: r = 8'h94; 8'h23: r = 8'h32; 8'h24: r = 8'ha6; 8'h25: r = 8'hc2; 8'h26: r = 8'h23; 8'h27: r = 8'h3d; 8'h28: r = 8'hee; 8'h29: r = 8'h4c; 8'h2a: r = 8'h95; 8'h2b: r = 8'h0b; 8'h2c: r = 8'h42; 8'h2d: r = 8'hfa; 8'h2e: r = 8'hc3; 8'h2f: r = 8'h4e;
            8'h30: r = 8'h08; 8'h31: r = 8'h2e; 8'h32: r = 8'ha1; 8'h33: r = 8'h66; 8'h34: r = 8'h28; 8'h35: r = 8'hd9; 8'h36: r = 8'h24; 8'h37: r = 8'hb2; 8'h38: r = 8'h76; 8'h39: r = 8'h5b; 8'h3a: r = 8'ha2; 8'h3b: r = 8'h49; 8'h3c: r = 8'h6d; 8'h3d: r = 8'h8b; 8'h3e: r = 8'hd1; 8'h3f: r = 8'h25;
            8'h40: r = 8'h72; 8'h41: r = 8'hf8; 8'h42: r = 8'hf6; 8'h43: r = 8'h64; 8'h44: r = 8'h86; 8'h45: r = 8'h68; 8'h46: r = 8'h98; 8'h47: r = 8'h16; 8'h48: r = 8'hd4; 8'h49: r = 8'ha4; 8'h4a: r = 8'h5c; 8'h4b: r = 8'hcc; 8'h4c: r = 8'h5d; 8'h4d: r = 8'h65; 8'h4e: r = 8'hb6; 8'h4f: r = 8'h92;
            8'h50: r = 8'h6c; 8'h51: r = 8'h70; 8'h52: r = 8'h48; 8'h53: r = 8'h50; 8'h54: r = 8'hfd; 8'h55: r = 8'hed; 8'h56: r = 8'hb9; 8'h57: r = 8'hda; 8'h58: r = 8'h5e; 8'h59: r = 8'h15; 8'h5a: r = 8'h46; 8'h5b: r = 8'h57; 8'h5c: r = 8'ha7; 8'h5d: r = 8'h8d; 8'h5e: r = 8'h9d; 8'h5f: r = 8'h84;
            8'h60: r = 8'h90; 8'h61: r = 8'hd8; 8'h62: r = 8'hab; 8'h63: r = 8'h00; 8'h64: r = 8'h8c; 8'h65: r = 8'hbc; 8'h66: r = 8'hd3; 8'h67: r = 8'h0a; 8'h68: r = 8'hf7; 8'h69: r = 8'he4; 8'h6a: r = 8'h58; 8'h6b: r = 8'h05; 8'h6c: r = 8'hb8; 8'h6d: r = 8'hb3; 8'h6e: r = 8'h45; 8'h6f: r = 8'h06;
            8'h70: r = 8'hd0; 8'h71: r = 8'h2c; 8'h72: r = 8'h1e; 8'h73: r = 8'h8f; 8'h74: r = 8'hca; 8'h75: r = 8'h3f; 8'h76: r = 8'h0f; 8'h77: r = 8'h02; 8'h78: r = 8'hc1; 8'h79: r = 8'haf; 8'h7a: r = 8'hbd; 8'h7b: r = 8'h03; 8'h7c: r = 8'h01; 8'h7d: r = 8'h13; 8'h7e: r = 8'h8a; 8'h7f: r = 8'h6b;
            8'h80: r = 8'h3a; 8'h81: r = 8'h91; 8'h82: r = 8'h11; 8'h83: r = 8'h41; 8'h84: r = 8'h4f; 8'h85: r = 8'h67; 8'h86: r = 8'hdc; 8'h87: r = 8'hea; 8'h88: r = 8'h97; 8'h89: r = 8'hf2; 8'h8a: r = 8'hcf; 8'h8b: r = 8'hce; 8'h8c: r = 8'hf0; 8'h8d: r = 8'hb4; 8'h8e: r = 8'he6; 8'h8f: r = 8'h73;
            8'h90: r = 8'h96; 8'h91: r = 8'hac; 8'h92: r = 8'h74; 8'h93: r = 8'h22; 8'h94: r = 8'he7; 8'h95: r = 8'had; 8'h96: r = 8'h35; 8'h97: r = 8'h85; 8'h98: r = 8'he2; 8'h99: r = 8'hf9; 8'h9a: r = 8'h37; 8'h9b: r = 8'he8; 8'h9c: r = 8'h1c; 8'h9d: r = 8'h75; 8'h9e: r = 8'hdf; 8'h9f: r = 8'h6e;
            8'ha0: r = 8'h47; 8'ha1: r = 8'hf1; 8'ha2: r = 8'h1a; 8'ha3: r = 8'h71; 8'ha4: r = 8'h1d; 8'ha5: r = 8'h29; 8'ha6: r = 8'hc5; 8'ha7: r = 8'h89; 8'ha8: r = 8'h6f; 8'ha9: r = 8'hb7; 8'haa: r = 8'h62; 8'hab: r = 8'h0e; 8'hac: r = 8'haa; 8'had: r = 8'h18; 8'hae: r = 8'hbe; 8'haf: r = 8'h1b;
            8'hb0: r = 8'hfc; 8'hb1: r = 8'h56; 8'hb2: r = 8'h3e; 8'hb3: r = 8'h4b; 8'hb4: r = 8'hc6; 8'hb5: r = 8'hd2; 8'hb6: r = 8'h79; 8'hb7: r = 8'h20; 8'hb8: r = 8'h9a; 8'hb9: r = 8'hdb; 8'hba: r = 8'hc0; 8'hbb: r = 8'hfe; 8'hbc: r = 8'h78; 8'hbd: r = 8'hcd; 8'hbe: r = 8'h5a; 8'hbf: r = 8'hf4;
            8'hc0: r = 8'h1f; 8'hc1: r = 8'hdd; 8'hc2: r = 8'ha8; 8'hc3: r = 8'h33; 8'hc4: r = 8'h88; 8'hc5: r = 8'h07; 8'hc6: r = 8'hc7; 8'hc7: r = 8'h31; 8'hc8: r = 8'hb1; 8'hc9: r = 8'h12; 8'hca: r = 8'h10; 8'hcb: r = 8'h59; 8'hcc: r = 8'h27; 8'hcd: r = 8'h80; 8'hce: r = 8'hec; 8'hcf: r = 8'h5f;
            8'hd0: r = 8'h60; 8'hd1: r = 8'h51; 8'hd2: r = 8'h7f; 8'hd3: r = 8'ha9; 8'hd4: r = 8'h19; 8'hd5: r = 8'hb5; 8'hd6: r = 8'h4a; 8'hd7: r = 8'h0d; 8'hd8: r = 8'h2d; 8'hd9: r = 8'he5; 8'hda: r = 8'h7a; 8'hdb: r = 8'h9f; 8'hdc: r = 8'h93; 8'hdd: r = 8'hc9; 8'hde: r = 8'h9c; 8'hdf: r = 8'hef;
            8'he0: r = 8'ha0; 8'he1: r = 8'he0; 8'he2: r = 8'h3b; 8'he3: r = 8'h4d; 8'he4: r = 8'hae; 8'he5: r = 8'h2a; 8'he6: r = 8'hf5; 8'he7: r = 8'hb0; 8'he8: r = 8'hc8; 8'he9: r = 8'heb; 8'hea: r = 8'hbb; 8'heb: r = 8'h3c; 8'hec: r = 8'h83; 8'hed: r = 8'h53; 8'hee: r = 8'h99; 8'hef: r = 8'h61;
            8'hf0: r = 8'h17; 8'hf1: r = 8'h2b; 8'hf2: r = 8'h04; 8'hf3: r = 8'h7e; 8'hf4: r = 8'hba; 8'hf5: r = 8'h77; 8'hf6: r = 8'hd6; 8'hf7: r = 8'h26; 8'hf8: r = 8'he1; 8'hf9: r = 8'h69; 8'hfa: r = 8'h14; 8'hfb: r = 8'h63; 8'hfc: r = 8'h55; 8'hfd: r = 8'h21; 8'hfe: r = 8'h0c; 8'hff: r = 8'h7d;
            default: r = 8'h00;
        endcase
        return r;
    endfunction

    // Multiply by x modulo x^8+x^4+x^3+x+1, result stays 8 bits.
    function automatic logic [7:0] xtime(input logic [7:0] a);
        return {a[6:0], 1'b0} ^ (a[7] ? 8'h1b : 8'h00);
    endfunction

    // Shift-and-add GF(2^8) multiply.
    function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
        logic [7:0] p;
        logic [7:0] x;
        p = 8'h00;
        x = a;
        for (int i = 0; i < 8; i++) begin
            if (b[i]) begin
                p = p ^ x;
            end
            x = xtime(x);
        end
        return p;
    endfunction

endpackage

// File: rtl/aes_inv_round.sv
// Combinational inverse round: InvShiftRows, InvSubBytes, AddRoundKey,
// then InvMixColumns when mix_en is high (omitted for the final round).
module aes_inv_round
    import aes_pkg::*;
(
    input  logic [127:0] state_in,
    input  logic [127:0] round_key,
    input  logic         mix_en,
    output logic [127:0] state_out
);

    logic [7:0] ark_b [0:15];
    logic [7:0] mix_b [0:15];

    // Byte gi sits at row gi%4, column gi/4; row r rotates right by r columns.
    for (genvar gi = 0; gi < 16; gi++) begin : g_byte
        localparam int ROW = gi % 4;
        localparam int COL = gi / 4;
        localparam int SRC = (((COL + 4 - ROW) % 4) * 4) + ROW;
        assign ark_b[gi] = inv_sbox(state_in[127-8*SRC -: 8]) ^ round_key[127-8*gi -: 8];
    end

    // InvMixColumns on each column with coefficients {0e,0b,0d,09}.
    for (genvar gi = 0; gi < 4; gi++) begin : g_col
        assign mix_b[4*gi+0] = gmul(ark_b[4*gi], 8'h0e) ^ gmul(ark_b[4*gi+1], 8'h0b) ^ gmul(ark_b[4*gi+2], 8'h0d) ^ gmul(ark_b[4*gi+3], 8'h09);
        assign mix_b[4*gi+1] = gmul(ark_b[4*gi], 8'h09) ^ gmul(ark_b[4*gi+1], 8'h0e) ^ gmul(ark_b[4*gi+2], 8'h0b) ^ gmul(ark_b[4*gi+3], 8'h0d);
        assign mix_b[4*gi+2] = gmul(ark_b[4*gi], 8'h0d) ^ gmul(ark_b[4*gi+1], 8'h09) ^ gmul(ark_b[4*gi+2], 8'h0e) ^ gmul(ark_b[4*gi+3], 8'h0b);
        assign mix_b[4*gi+3] = gmul(ark_b[4*gi], 8'h0b) ^ gmul(ark_b[4*gi+1], 8'h0d) ^ gmul(ark_b[4*gi+2], 8'h09) ^ gmul(ark_b[4*gi+3], 8'h0e);
    end

    for (genvar gi = 0; gi < 16; gi++) begin : g_out
        assign state_out[127-8*gi -: 8] = mix_en ? mix_b[gi] : ark_b[gi];
    end

endmodule

// File: rtl/aes128_decrypt.sv
// Iterative AES-128 decryption, one round per clock, self-starting after reset.
// Key schedule is expanded up front into rk_reg[0:10], then consumed in reverse.
// Build option: define AES_DEBUG_OUT_EN to expose state_out/round_count_out;
// otherwise both are tied to zero.
module aes128_decrypt
    import aes_pkg::*;
(
    input  logic         clk,
    input  logic         rst,
    input  logic [127:0] ciphertext,
    input  logic [127:0] key,
    output logic [127:0] plaintext,
    output logic         done,
    output logic [3:0]   round_count_out,
    output logic [127:0] state_out
);

    fsm_state_t   fsm_reg, fsm_next;
    logic [3:0]   cnt_reg, cnt_next;
    logic [127:0] state_reg, state_next;
    logic [127:0] plaintext_reg, plaintext_next;
    logic         done_reg, done_next;

    logic [127:0] rk_reg  [0:NR];
    logic [127:0] rk_next [0:NR];

    logic [127:0] rk_prev, rk_expand, round_key, round_out;
    logic [31:0]  w0, w1, w2, w3, temp, n0, n1, n2, n3;

    // Next round key from the previous one: RotWord, SubWord, Rcon, XOR chain.
    always_comb begin
        rk_prev = rk_reg[cnt_reg - 4'd1];
        w0 = rk_prev[127:96];
        w1 = rk_prev[95:64];
        w2 = rk_prev[63:32];
        w3 = rk_prev[31:0];
        temp = {sbox(w3[23:16]) ^ RCON[cnt_reg], sbox(w3[15:8]), sbox(w3[7:0]), sbox(w3[31:24])};
        n0 = w0 ^ temp;
        n1 = w1 ^ n0;
        n2 = w2 ^ n1;
        n3 = w3 ^ n2;
        rk_expand = {n0, n1, n2, n3};
    end

    // rk[0] takes the cipher key in LOAD; rk[i] is written once, when cnt==i in KEYEXP.
    assign rk_next[0] = (fsm_reg == S_LOAD) ? key : rk_reg[0];
    for (genvar gi = 1; gi <= NR; gi++) begin : g_rk
        assign rk_next[gi] = ((fsm_reg == S_KEYEXP) && (cnt_reg == 4'(gi))) ? rk_expand : rk_reg[gi];
    end

    // Round-key storage, cleared on reset.
    always_ff @(posedge clk) begin
        for (int i = 0; i <= NR; i++) begin
            rk_reg[i] <= rst ? 128'd0 : rk_next[i];
        end
    end

    assign round_key = (fsm_reg == S_FINAL) ? rk_reg[0] : rk_reg[cnt_reg];

    aes_inv_round u_inv_round (
        .state_in  (state_reg),
        .round_key (round_key),
        .mix_en    (fsm_reg == S_ROUND),
        .state_out (round_out)
    );

    // FSM and datapath registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            fsm_reg       <= S_LOAD;
            cnt_reg       <= 4'd0;
            state_reg     <= 128'd0;
            plaintext_reg <= 128'd0;
            done_reg      <= 1'b0;
        end else begin
            fsm_reg       <= fsm_next;
            cnt_reg       <= cnt_next;
            state_reg     <= state_next;
            plaintext_reg <= plaintext_next;
            done_reg      <= done_next;
        end
    end

    // Next-state and datapath update for LOAD -> KEYEXP -> INIT -> ROUND -> FINAL -> DONE.
    always_comb begin
        fsm_next       = fsm_reg;
        cnt_next       = cnt_reg;
        state_next     = state_reg;
        plaintext_next = plaintext_reg;
        done_next      = done_reg;
        case (fsm_reg)
            S_LOAD: begin
                state_next = ciphertext;
                cnt_next   = 4'd1;
                fsm_next   = S_KEYEXP;
            end
            S_KEYEXP: begin
                if (cnt_reg == 4'(NR)) begin
                    fsm_next = S_INIT;
                end else begin
                    cnt_next = cnt_reg + 4'd1;
                end
            end
            S_INIT: begin
                state_next = state_reg ^ rk_reg[NR];
                cnt_next   = 4'(NR - 1);
                fsm_next   = S_ROUND;
            end
            S_ROUND: begin
                state_next = round_out;
                if (cnt_reg == 4'd1) begin
                    cnt_next = 4'd0;
                    fsm_next = S_FINAL;
                end else begin
                    cnt_next = cnt_reg - 4'd1;
                end
            end
            S_FINAL: begin
                state_next     = round_out;
                plaintext_next = round_out;
                done_next      = 1'b1;
                cnt_next       = 4'd0;
                fsm_next       = S_DONE;
            end
            S_DONE: begin
                fsm_next = S_DONE;
            end
            default: begin
                fsm_next = S_LOAD;
            end
        endcase
    end

    assign plaintext = plaintext_reg;
    assign done      = done_reg;

`ifdef AES_DEBUG_OUT_EN
    assign state_out       = state_reg;
    assign round_count_out = cnt_reg;
`else
    assign state_out       = 128'd0;
    assign round_count_out = 4'd0;
`endif

endmodule

// File: tb/tb_aes128_decrypt.sv
// Self-checking bench for aes128_decrypt: known-answer vectors through a
// scoreboard queue, latency/hold, mid-operation reset, and debug outputs.
module tb_aes128_decrypt;

    logic         clk = 1'b0;
    logic         rst;
    logic [127:0] ciphertext;
    logic [127:0] key;
    logic [127:0] plaintext;
    logic         done;
    logic [3:0]   round_count_out;
    logic [127:0] state_out;

    int checks = 0;
    int errors = 0;
    logic [127:0] sb_q [$];

    localparam logic [127:0] K1  = 128'h000102030405060708090a0b0c0d0e0f;
    localparam logic [127:0] C1  = 128'h69c4e0d86a7b0430d8cdb78070b4c55a;
    localparam logic [127:0] P1  = 128'h00112233445566778899aabbccddeeff;
    localparam logic [127:0] K2  = 128'h2b7e151628aed2a6abf7158809cf4f3c;
    localparam logic [127:0] C2  = 128'h3ad77bb40d7a3660a89ecaf32466ef97;
    localparam logic [127:0] P2  = 128'h6bc1bee22e409f96e93d7e117393172a;
    localparam logic [127:0] C3  = 128'h3925841d02dc09fbdc118597196a0b32;
    localparam logic [127:0] P3  = 128'h3243f6a8885a308d313198a2e0370734;
    localparam logic [127:0] RK10_1 = 128'h13111d7fe3944a17f307a78b4d2b30c5;

    aes128_decrypt dut (
        .clk             (clk),
        .rst             (rst),
        .ciphertext      (ciphertext),
        .key             (key),
        .plaintext       (plaintext),
        .done            (done),
        .round_count_out (round_count_out),
        .state_out       (state_out)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Hold reset for one edge with new inputs, then release; expectation queued.
    task automatic start_op(input logic [127:0] k, input logic [127:0] c, input logic [127:0] exp);
        rst = 1'b1;
        key = k;
        ciphertext = c;
        tick();
        sb_q.push_back(exp);
        rst = 1'b0;
    endtask

    // Wait (bounded) for done, check the 22-edge latency and pop the scoreboard.
    task automatic wait_result(input string name);
        int edges;
        logic [127:0] exp;
        edges = 0;
        while (!done && edges < 40) begin
            tick();
            edges++;
        end
        exp = sb_q.pop_front();
        checks++;
        if (!done) begin
            errors++;
            $display("FAIL %s timeout: done=%0b after %0d edges, required done=1", name, done, edges);
        end else begin
            if (edges != 22) begin
                errors++;
                $display("FAIL %s latency: %0d edges, required 22", name, edges);
            end
            checks++;
            if (plaintext !== exp) begin
                errors++;
                $display("FAIL %s plaintext: got %h required %h", name, plaintext, exp);
            end else begin
                $display("txn %s plaintext=%h edges=%0d", name, plaintext, edges);
            end
        end
    endtask

    task automatic test_reset();
        rst = 1'b1;
        key = K1;
        ciphertext = C1;
        repeat (3) tick();
        checks++;
        if ({done, plaintext} !== 129'd0) begin
            errors++;
            $display("FAIL reset_out: done=%0b plaintext=%h required 0", done, plaintext);
        end
        checks++;
        if ({round_count_out, state_out} !== 132'd0) begin
            errors++;
            $display("FAIL reset_dbg: rc=%0d state=%h required 0", round_count_out, state_out);
        end
        $display("txn reset done=%0b plaintext=%h", done, plaintext);
    endtask

    task automatic test_vectors();
        start_op(K1, C1, P1);
        wait_result("vec1");
        start_op(K2, C2, P2);
        wait_result("vec2");
        start_op(K2, C3, P3);
        wait_result("vec3");
    endtask

    // done low for edges 1..21, high at 22; inputs scrambled after LOAD; 100-clock hold.
    task automatic test_latency_hold();
        logic [127:0] exp;
        int bad;
        start_op(K1, C1, P1);
        bad = 0;
        for (int e = 1; e <= 22; e++) begin
            tick();
            if (e == 1) begin
                ciphertext = {$urandom, $urandom, $urandom, $urandom};
                key = {$urandom, $urandom, $urandom, $urandom};
            end
            checks++;
            if (done !== (e == 22)) begin
                errors++;
                bad++;
                $display("FAIL latency_edge%0d: done=%0b required %0b", e, done, (e == 22));
            end
        end
        exp = sb_q.pop_front();
        checks++;
        if (plaintext !== exp) begin
            errors++;
            $display("FAIL latency_pt: got %h required %h", plaintext, exp);
        end
        for (int h = 0; h < 100; h++) begin
            ciphertext = {$urandom, $urandom, $urandom, $urandom};
            key = {$urandom, $urandom, $urandom, $urandom};
            tick();
            checks++;
            if ({done, plaintext} !== {1'b1, exp}) begin
                errors++;
                bad++;
                $display("FAIL hold_%0d: done=%0b pt=%h required done=1 pt=%h", h, done, plaintext, exp);
            end
        end
        $display("txn latency_hold plaintext=%h bad=%0d", plaintext, bad);
    endtask

    // Reset pulse during round 5 restarts on the inputs present at release.
    task automatic test_mid_reset();
        rst = 1'b1;
        key = K1;
        ciphertext = C1;
        tick();
        rst = 1'b0;
        repeat (16) tick();
        rst = 1'b1;
        key = K2;
        ciphertext = C2;
        tick();
        checks++;
        if ({done, plaintext, round_count_out, state_out} !== 261'd0) begin
            errors++;
            $display("FAIL midrst_out: done=%0b pt=%h rc=%0d state=%h required 0", done, plaintext, round_count_out, state_out);
        end
        sb_q.push_back(P2);
        rst = 1'b0;
        wait_result("midrst_vec2");
    endtask

    function automatic int exp_rc(input int e);
        if (e <= 10) return e;
        if (e == 11) return 10;
        if (e <= 20) return 21 - e;
        return 0;
    endfunction

    // Debug outputs follow the round counter / state (or stay 0 without the option).
    task automatic test_debug();
        int bad;
        bad = 0;
        start_op(K1, C1, P1);
        checks++;
        if (round_count_out !== 4'd0) begin
            errors++;
            $display("FAIL dbg_rc_load: got %0d required 0", round_count_out);
        end
        for (int e = 1; e <= 22; e++) begin
            tick();
`ifdef AES_DEBUG_OUT_EN
            checks++;
            if (round_count_out !== 4'(exp_rc(e))) begin
                errors++;
                bad++;
                $display("FAIL dbg_rc_edge%0d: got %0d required %0d", e, round_count_out, exp_rc(e));
            end
            if (e == 1) begin
                checks++;
                if (state_out !== C1) begin
                    errors++;
                    $display("FAIL dbg_state_load: got %h required %h", state_out, C1);
                end
            end
            if (e == 12) begin
                checks++;
                if (state_out !== (C1 ^ RK10_1)) begin
                    errors++;
                    $display("FAIL dbg_state_init: got %h required %h", state_out, C1 ^ RK10_1);
                end
            end
`else
            checks++;
            if ({round_count_out, state_out} !== 132'd0) begin
                errors++;
                bad++;
                $display("FAIL dbg_tied_edge%0d: rc=%0d state=%h required 0", e, round_count_out, state_out);
            end
`endif
        end
        $display("txn debug rc=%0d bad=%0d", round_count_out, bad);
        checks++;
        if ({done, plaintext} !== {1'b1, sb_q.pop_front()}) begin
            errors++;
            $display("FAIL dbg_result: done=%0b pt=%h required done=1 pt=%h", done, plaintext, P1);
        end
    endtask

    initial begin
        rst = 1'b1;
        key = '0;
        ciphertext = '0;
        test_reset();
        test_vectors();
        test_latency_hold();
        test_mid_reset();
        test_debug();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
